// File: rtl/hs32_conds.sv
// HS32 shared definitions: condition codes, nzcv bit indices, buffer entry.
// No ports; imported by the writeback stage and its condition evaluator.
package hs32_conds;

  localparam logic [2:0] HS32C_AL = 3'd0;
  localparam logic [2:0] HS32C_EQ = 3'd1;
  localparam logic [2:0] HS32C_NE = 3'd2;
  localparam logic [2:0] HS32C_CS = 3'd3;
  localparam logic [2:0] HS32C_CC = 3'd4;
  localparam logic [2:0] HS32C_MI = 3'd5;
  localparam logic [2:0] HS32C_LT = 3'd6;
  localparam logic [2:0] HS32C_GE = 3'd7;

  localparam int FL_N = 3;
  localparam int FL_Z = 2;
  localparam int FL_C = 1;
  localparam int FL_V = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  fl;
    logic        wen;
    logic        flen;
    logic [2:0]  cond;
  } wb_ent_t;

endpackage

// File: rtl/hs32_cond_eval.sv
// Condition-code evaluator: cond[2:0] + nzcv[3:0] -> pass.
// Purely combinational.
module hs32_cond_eval
  import hs32_conds::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  always_comb begin
    pass = 1'b1;
    unique case (cond)
      HS32C_AL: pass = 1'b1;
      HS32C_EQ: pass = nzcv[FL_Z];
      HS32C_NE: pass = !nzcv[FL_Z];
      HS32C_CS: pass = nzcv[FL_C];
      HS32C_CC: pass = !nzcv[FL_C];
      HS32C_MI: pass = nzcv[FL_N];
      HS32C_LT: pass = nzcv[FL_N] ^ nzcv[FL_V];
      HS32C_GE: pass = !(nzcv[FL_N] ^ nzcv[FL_V]);
    endcase
  end

endmodule

// File: rtl/hs32_wb.sv
// HS32 writeback/commit stage: 2-entry buffer, cond check, RF write, NZCV.
// Ports: valid/ready input side, flush/stall, RF write port, o_fl, o_skip.
module hs32_wb
  import hs32_conds::*;
#(
  parameter int DEPTH = 2,
  parameter int RF_AW = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_r,
  input  logic [3:0]       i_fl,
  input  logic [RF_AW-1:0] i_rd,
  input  logic             i_wen,
  input  logic             i_flen,
  input  logic [2:0]       i_cond,
  input  logic             i_flush,
  input  logic             i_stall,
  output logic             o_rf_we,
  output logic [RF_AW-1:0] o_rf_addr,
  output logic [31:0]      o_rf_data,
  output logic [3:0]       o_fl,
  output logic             o_skip
);

  if (DEPTH != 2) begin : g_depth_chk
    $error("hs32_wb: only DEPTH=2 is supported");
  end

  wb_ent_t          mem [2];
  logic [RF_AW-1:0] rds [2];

  logic [1:0] count;
  logic [1:0] cnt_nx;
  logic       wp;
  logic       rp;
  logic       push;
  logic       pop;
  logic       pass;
  wb_ent_t    head;
  wb_ent_t    in_ent;

  assign push = i_valid && o_ready && !i_flush;
  assign pop  = (count != 2'd0) && !i_stall && !i_flush;
  assign head = mem[rp];

  assign in_ent = '{
    r:    i_r,
    fl:   i_fl,
    wen:  i_wen,
    flen: i_flen,
    cond: i_cond
  };

  hs32_cond_eval u_cond (
    .cond (head.cond),
    .nzcv (o_fl),
    .pass (pass)
  );

  always_comb begin
    cnt_nx = count;
    unique case ({push, pop})
      2'b10:   cnt_nx = count + 2'd1;
      2'b01:   cnt_nx = count - 2'd1;
      default: cnt_nx = count;
    endcase
  end

  // Storage needs no reset: count alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= in_ent;
      rds[wp] <= i_rd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count     <= 2'd0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      o_ready   <= 1'b1;
      o_rf_we   <= 1'b0;
      o_rf_addr <= '0;
      o_rf_data <= '0;
      o_fl      <= 4'b0000;
      o_skip    <= 1'b0;
    end else begin
      if (i_flush) begin
        count   <= 2'd0;
        wp      <= 1'b0;
        rp      <= 1'b0;
        o_ready <= 1'b1;
      end else begin
        count   <= cnt_nx;
        o_ready <= (cnt_nx != 2'd2);
        if (push) wp <= ~wp;
        if (pop)  rp <= ~rp;
      end
      o_rf_we <= pop && pass && head.wen;
      o_skip  <= pop && !pass;
      if (pop) begin
        o_rf_addr <= rds[rp];
        o_rf_data <= head.r;
        if (pass && head.flen) o_fl <= head.fl;
      end
    end
  end

endmodule

// File: tb/tb_hs32_wb.sv
// Self-checking bench for hs32_wb: queue scoreboard plus cond vector table.
// Inputs change #1 after posedge; outputs are compared #1 after posedge.
module tb_hs32_wb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_r;
  logic [3:0]  i_fl;
  logic [3:0]  i_rd;
  logic        i_wen;
  logic        i_flen;
  logic [2:0]  i_cond;
  logic        i_flush;
  logic        i_stall;
  logic        o_rf_we;
  logic [3:0]  o_rf_addr;
  logic [31:0] o_rf_data;
  logic [3:0]  o_fl;
  logic        o_skip;

  always #5 clk = ~clk;

  hs32_wb #(.DEPTH(2), .RF_AW(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_r       (i_r),
    .i_fl      (i_fl),
    .i_rd      (i_rd),
    .i_wen     (i_wen),
    .i_flen    (i_flen),
    .i_cond    (i_cond),
    .i_flush   (i_flush),
    .i_stall   (i_stall),
    .o_rf_we   (o_rf_we),
    .o_rf_addr (o_rf_addr),
    .o_rf_data (o_rf_data),
    .o_fl      (o_fl),
    .o_skip    (o_skip)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  fl;
    logic [3:0]  rd;
    logic        wen;
    logic        flen;
    logic [2:0]  cond;
  } ent_t;

  typedef struct {
    logic [3:0] pre;
    logic [2:0] cond;
    logic       exp_pass;
  } vec_t;

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [3:0]  mfl;
  logic        m_ready;
  logic        e_we;
  logic        e_skip;
  logic [3:0]  e_addr;
  logic [31:0] e_data;
  logic        last_push;
  int          we_cnt;
  int          skip_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [2:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return ~z;
      3'd3: return cy;
      3'd4: return ~cy;
      3'd5: return n;
      3'd6: return n != v;
      default: return n == v;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] r,
                       input logic [3:0] fl, input logic [3:0] rd,
                       input logic wen, input logic flen,
                       input logic [2:0] cond);
    i_valid = v; i_r = r; i_fl = fl; i_rd = rd;
    i_wen = wen; i_flen = flen; i_cond = cond;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    mfl = 4'b0000;
    m_ready = 1'b1;
    e_we = 1'b0; e_skip = 1'b0;
    e_addr = 4'h0; e_data = 32'h0;
  endtask

  task automatic cycle();
    bit   pu, po, ps;
    ent_t h, n;
    n = '{r: i_r, fl: i_fl, rd: i_rd, wen: i_wen, flen: i_flen,
          cond: i_cond};
    pu = i_valid && m_ready && !i_flush;
    po = (mq.size() != 0) && !i_stall && !i_flush;
    e_we = 1'b0;
    e_skip = 1'b0;
    if (po) begin
      h = mq.pop_front();
      ps = cond_ok(h.cond, mfl);
      e_we = ps && h.wen;
      e_skip = !ps;
      e_addr = h.rd;
      e_data = h.r;
      if (ps && h.flen) mfl = h.fl;
    end
    if (i_flush) mq.delete();
    else if (pu) mq.push_back(n);
    m_ready = (mq.size() != 2);
    last_push = pu;
    @(posedge clk);
    #1;
    chk("ready", o_ready, m_ready);
    chk("rf_we", o_rf_we, e_we);
    chk("skip", o_skip, e_skip);
    chk("flags", o_fl, mfl);
    chk("addr", o_rf_addr, e_addr);
    chk("data", o_rf_data, e_data);
    we_cnt += o_rf_we;
    skip_cnt += o_skip;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'b0000, 3'd0, 1'b1};
    tbl[1]  = '{4'b0100, 3'd1, 1'b1};
    tbl[2]  = '{4'b0000, 3'd1, 1'b0};
    tbl[3]  = '{4'b0100, 3'd2, 1'b0};
    tbl[4]  = '{4'b0010, 3'd3, 1'b1};
    tbl[5]  = '{4'b0010, 3'd4, 1'b0};
    tbl[6]  = '{4'b0000, 3'd4, 1'b1};
    tbl[7]  = '{4'b1000, 3'd5, 1'b1};
    tbl[8]  = '{4'b1000, 3'd6, 1'b1};
    tbl[9]  = '{4'b1001, 3'd6, 1'b0};
    tbl[10] = '{4'b1001, 3'd7, 1'b1};
    tbl[11] = '{4'b0001, 3'd7, 1'b0};

    rstn = 1'b0;
    i_flush = 1'b0;
    i_stall = 1'b0;
    idle();
    model_reset();
    we_cnt = 0;
    skip_cnt = 0;
    #12;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_we", o_rf_we, 1'b0);
    chk("rst_fl", o_fl, 4'b0000);
    chk("rst_skip", o_skip, 1'b0);
    chk("rst_addr", o_rf_addr, 4'h0);
    chk("rst_data", o_rf_data, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // single AL commit: two edges push -> o_rf_we
    drive(1'b1, 32'hDEADBEEF, 4'b0100, 4'd5, 1'b1, 1'b1, 3'd0);
    cycle();
    idle();
    chk("lat_early", o_rf_we, 1'b0);
    cycle();
    chk("lat_we", o_rf_we, 1'b1);
    chk("lat_addr", o_rf_addr, 4'd5);
    chk("lat_data", o_rf_data, 32'hDEADBEEF);
    chk("lat_fl", o_fl, 4'b0100);
    cycle();

    // NE with Z set: skipped
    drive(1'b1, 32'h1234, 4'b1111, 4'd7, 1'b1, 1'b1, 3'd2);
    cycle();
    idle();
    we_cnt = 0; skip_cnt = 0;
    repeat (3) cycle();
    chk("ne_we", we_cnt, 0);
    chk("ne_skip", skip_cnt, 1);
    chk("ne_fl", o_fl, 4'b0100);

    // table: flags-setting A then dependent B back-to-back
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'hA0 + i, tbl[i].pre, 4'd0, 1'b0, 1'b1, 3'd0);
      cycle();
      drive(1'b1, 32'hB0 + i, 4'hF, 4'(i + 1), 1'b1, 1'b0, tbl[i].cond);
      cycle();
      idle();
      we_cnt = 0; skip_cnt = 0;
      repeat (3) cycle();
      chk($sformatf("tbl%0d_we", i), we_cnt, 32'(tbl[i].exp_pass));
      chk($sformatf("tbl%0d_skip", i), skip_cnt, 32'(!tbl[i].exp_pass));
      chk($sformatf("tbl%0d_fl", i), o_fl, tbl[i].pre);
    end

    // stall: two accepted, third held until space frees
    i_stall = 1'b1;
    drive(1'b1, 32'h11, 4'h0, 4'd1, 1'b1, 1'b0, 3'd0);
    cycle();
    drive(1'b1, 32'h22, 4'h0, 4'd2, 1'b1, 1'b0, 3'd0);
    cycle();
    chk("stall_full", o_ready, 1'b0);
    drive(1'b1, 32'h33, 4'h0, 4'd3, 1'b1, 1'b0, 3'd0);
    we_cnt = 0;
    repeat (2) cycle();
    chk("stall_held", we_cnt, 0);
    i_stall = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        cycle();
        n++;
      end while (!last_push && n < 10);
      chk("stall_accept_bound", 32'(last_push), 32'd1);
    end
    idle();
    repeat (4) cycle();
    chk("stall_commits", we_cnt, 3);
    chk("stall_ready", o_ready, 1'b1);

    // flush while full with a concurrent push
    i_stall = 1'b1;
    drive(1'b1, 32'h44, 4'h0, 4'd4, 1'b1, 1'b0, 3'd0);
    cycle();
    drive(1'b1, 32'h55, 4'h0, 4'd5, 1'b1, 1'b0, 3'd0);
    cycle();
    i_flush = 1'b1;
    i_stall = 1'b0;
    drive(1'b1, 32'h66, 4'h0, 4'd6, 1'b1, 1'b0, 3'd0);
    we_cnt = 0;
    cycle();
    chk("flush_ready", o_ready, 1'b1);
    i_flush = 1'b0;
    idle();
    repeat (4) cycle();
    chk("flush_no_we", we_cnt, 0);

    // set nonzero flags, fill, then reset mid-stream
    drive(1'b1, 32'h77, 4'b1010, 4'd7, 1'b1, 1'b1, 3'd0);
    cycle();
    idle();
    repeat (2) cycle();
    chk("pre_rst_fl", o_fl, 4'b1010);
    i_stall = 1'b1;
    drive(1'b1, 32'h88, 4'h0, 4'd8, 1'b1, 1'b0, 3'd0);
    cycle();
    drive(1'b1, 32'h99, 4'h0, 4'd9, 1'b1, 1'b0, 3'd0);
    cycle();
    chk("pre_rst_full", o_ready, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_ready", o_ready, 1'b1);
    chk("arst_we", o_rf_we, 1'b0);
    chk("arst_fl", o_fl, 4'b0000);
    model_reset();
    idle();
    i_stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    we_cnt = 0; skip_cnt = 0;
    repeat (4) cycle();
    chk("post_rst_we", we_cnt, 0);
    chk("post_rst_skip", skip_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs32_wb.md
Name: hs32_wb

Overview:
- Writeback/commit stage directly downstream of the HS32 ALU.
- Accepts ALU result, NZCV flags and destination info through a valid/ready handshake into a 2-entry buffer.
- Evaluates the instruction's condition code against the architectural flags register, then commits the result to the register-file write port and optionally updates flags.
- Owns the architectural NZCV register and drives it back to the ALU flag input.

Parameters:
- DEPTH, 2, buffer entries; only 2 supported, checked by elaboration assertion.
- RF_AW, 4, register-file address width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream entry valid.
- o_ready  output  1  buffer can accept; registered, equals (count != 2).
- i_r  input  32  ALU result.
- i_fl  input  4  ALU flags out, nzcv.
- i_rd  input  RF_AW  destination register.
- i_wen  input  1  write i_r to i_rd if condition passes.
- i_flen  input  1  copy i_fl to flags register if condition passes.
- i_cond  input  3  condition code.
- i_flush  input  1  discard all buffered, uncommitted entries.
- i_stall  input  1  register-file port busy; no pop this cycle.
- o_rf_we  output  1  register-file write strobe, one cycle per commit.
- o_rf_addr  output  RF_AW  write address.
- o_rf_data  output  32  write data.
- o_fl  output  4  architectural nzcv; feeds ALU i_fl.
- o_skip  output  1  one-cycle pulse when a popped entry fails its condition.

Behaviour:
- Reset (async, rstn=0): count=0, pointers=0, o_ready=1, o_rf_we=0, o_rf_addr=0, o_rf_data=0, o_fl=4'b0000, o_skip=0.
- Push occurs when i_valid && o_ready && !i_flush. Entry stores {r, fl, rd, wen, flen, cond} at the write pointer. The pointer wraps 1 to 0.
- Pop occurs when count!=0 && !i_stall && !i_flush. The head entry is read at the read pointer, which wraps 1 to 0.
- Buffer states: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - Push only: count +1.
  - Pop only: count -1.
  - Push and pop together: count unchanged. This is legal in ONE; in EMPTY only the push happens.
- No bypass: data pushed at edge N can pop at edge N+1 at the earliest.
- Condition pass is evaluated on the head entry against the current o_fl:
  - 0 AL: always.
  - 1 EQ: Z.
  - 2 NE: !Z.
  - 3 CS: C.
  - 4 CC: !C.
  - 5 MI: N.
  - 6 LT: N^V.
  - 7 GE: !(N^V).
- At a pop edge, all outputs are registered:
  - o_rf_we <= pass && wen.
  - o_rf_addr/o_rf_data <= head rd/r, loaded on every pop.
  - o_fl <= head fl if pass && flen.
  - o_skip <= !pass.
- Latency: push at edge N into an empty buffer with no stall gives o_rf_we high during the cycle after edge N+1.
- Back-to-back pops: the second pop evaluates against flags already updated by the first. There is no flag hazard.
- On edges with no pop: o_rf_we=0, o_skip=0, addr/data hold.
- i_stall=1 freezes the read side. Pushes continue until FULL.
- i_flush=1:
  - Next edge: count=0, both pointers reset to 0, any concurrent push is dropped, no pop.
  - The output register and o_fl are unaffected; a commit already registered still completes.
- o_ready is registered from the next-state count. Upstream must not depend on a same-cycle response.
- Mid-operation reset: all entries are lost and the flags clear asynchronously.

Decomposition:
- Shared package/include hs32_conds holds:
  - condition code constants (HS32C_AL..HS32C_GE);
  - flag bit index constants (N=3, Z=2, C=1, V=0), matching the ALU nzcv ordering.
- One natural sub-module, hs32_cond_eval: combinational, cond[2:0] + nzcv[3:0] -> pass.
- The buffer stays inline.

Test Plan:
- Reset then single push {r=32'hDEADBEEF, rd=5, wen=1, flen=1, fl=4'b0100, cond=AL} -> o_rf_we=1, addr=5, data=DEADBEEF two edges after push; o_fl=4'b0100 on the same edge.
- With o_fl Z=1, push cond=NE, wen=1 -> o_rf_we stays 0, o_skip pulses once, o_fl unchanged.
- Back-to-back: entry A {flen=1, fl=4'b0000, cond=AL}, then B {cond=EQ, wen=1} -> B skipped. Repeat with A fl=4'b0100 -> B commits.
- i_stall=1, push 3 entries -> o_ready drops after the 2nd accept and the 3rd is held. Release stall -> commits in order, one per cycle, o_ready returns to 1.
- FULL plus i_flush with i_valid=1 -> count=0, no o_rf_we from flushed entries, input dropped, o_ready=1 next cycle.
- Assert rstn=0 mid-stream while FULL -> immediate o_ready=1, o_rf_we=0, o_fl=0. No stale commits after release.
